video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 46 ++++
 rtl/video_timing_gen_ce_divider.sv | 33 +++
 rtl/video_timing_gen.sv | 95 +++++++++
 tb/tb_video_timing_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared helpers for the video timing generator: raster arithmetic,
// counter sizing, parameter validation and the sync/blank bundle type.
package video_timing_pkg;

    localparam int DEF_CE_DIV   = 4;
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } sync_t;

    function automatic int raster_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    function automatic bit params_ok(input int ce_div,
                                     input int h_fp, input int h_sync, input int h_bp,
                                     input int v_fp, input int v_sync, input int v_bp);
        return (ce_div >= 1) && (h_fp >= 1) && (h_sync >= 1) && (h_bp >= 1) &&
               (v_fp >= 1) && (v_sync >= 1) && (v_bp >= 1);
    endfunction

endpackage

// File: rtl/video_timing_gen_ce_divider.sv
// Pixel clock-enable divider: registered one-cycle pulse every CE_DIV clk_sys
// cycles, aligned so the pulse sits in the cycle where the phase is CE_DIV-1.
module ce_divider #(
    parameter int CE_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    output logic ce
);

    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CE_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    always_comb begin
        div_next = (div == LAST) ? '0 : div + DW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div <= '0;
            ce  <= 1'b0;
        end else begin
            div <= div_next;
            ce  <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Fixed-mode raster timing generator: pixel/line counters advanced on ce_pix,
// with sync/blank decoded from the next counter values so they align with hcount/vcount.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CE_DIV   = DEF_CE_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk_sys,
    input  logic          reset,
    output logic          ce_pix,
    output logic          HSync,
    output logic          VSync,
    output logic          HBlank,
    output logic          VBlank,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount
);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_BLANK_START = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] H_SYNC_END   = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [VW-1:0] V_BLANK_START = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] V_SYNC_END   = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    if (!params_ok(CE_DIV, H_FP, H_SYNC, H_BP, V_FP, V_SYNC, V_BP)) begin : g_bad_params
        $fatal(1, "video_timing_gen: CE_DIV and all porch/sync widths must be >= 1");
    end

    ce_divider #(
        .CE_DIV (CE_DIV)
    ) u_ce_divider (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce_pix)
    );

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    sync_t         flags_next;

    // NOTE: every always_comb output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (ce_pix) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                v_next = (vcount == V_LAST) ? '0 : vcount + VW'(1);
            end else begin
                h_next = hcount + HW'(1);
            end
        end

        flags_next.hblank = (h_next >= H_BLANK_START);
        flags_next.hsync  = (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
        flags_next.vblank = (v_next >= V_BLANK_START);
        flags_next.vsync  = (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
    end

    // Decoding the next values keeps flags and counters in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
            HSync  <= 1'b0;
            VSync  <= 1'b0;
            HBlank <= 1'b0;
            VBlank <= 1'b0;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
            HSync  <= flags_next.hsync;
            VSync  <= flags_next.vsync;
            HBlank <= flags_next.hblank;
            VBlank <= flags_next.vblank;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a raster reference model feeds a
// per-cycle expectation queue that is compared against two DUTs (CE_DIV=4 and 1).
module tb_video_timing_gen;

    typedef struct packed {
        logic       ce;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic [3:0] h;
        logic [2:0] v;
    } obs_t;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;

    logic       ce4, hs4, vs4, hb4, vb4;
    logic [3:0] h4;
    logic [2:0] v4;
    logic       ce1, hs1, vs1, hb1, vb1;
    logic [3:0] h1;
    logic [2:0] v1;

    obs_t obs4;
    obs_t obs1;
    assign obs4 = {ce4, hs4, vs4, hb4, vb4, h4, v4};
    assign obs1 = {ce1, hs1, vs1, hb1, vb1, h1, v1};

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   t            = 0;
    obs_t exp_q[$];

    always #5 clk_sys = ~clk_sys;

    video_timing_gen #(
        .CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut4 (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce4),
        .HSync (hs4), .VSync (vs4), .HBlank (hb4), .VBlank (vb4),
        .hcount (h4), .vcount (v4)
    );

    video_timing_gen #(
        .CE_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut1 (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce1),
        .HSync (hs1), .VSync (vs1), .HBlank (hb1), .VBlank (vb1),
        .hcount (h1), .vcount (v1)
    );

    // Expected state in cycle t after reset release (cycle 0 holds reset values).
    function automatic obs_t model(input int cyc, input int div);
        obs_t m;
        int   p;
        int   hh;
        int   vv;
        m.ce = (div == 1) ? (cyc > 0) : ((cyc % div) == (div - 1));
        p    = (div == 1) ? ((cyc > 0) ? cyc - 1 : 0) : cyc / div;
        hh   = p % 16;
        vv   = (p / 16) % 8;
        m.h  = 4'(hh);
        m.v  = 3'(vv);
        m.hb = (hh >= 8);
        m.hs = (hh >= 10) && (hh < 13);
        m.vb = (vv >= 4);
        m.vs = (vv >= 5) && (vv < 7);
        return m;
    endfunction

    // Leaves the bench at the falling edge of cycle 0 with reset released.
    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        t = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        tests_run++;
        if (obs4 !== '0) begin
            tests_failed++;
            $display("FAIL reset_div4 got=%h exp=%h", obs4, obs_t'(0));
        end
        tests_run++;
        if (obs1 !== '0) begin
            tests_failed++;
            $display("FAIL reset_div1 got=%h exp=%h", obs1, obs_t'(0));
        end
    endtask

    task automatic test_ce_schedule();
        obs_t e;
        do_reset();
        exp_q.push_back(model(0, 4));
        for (int i = 0; i < 24; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs4 !== e) begin
                tests_failed++;
                $display("FAIL ce_schedule t=%0d got=%h exp=%h", t, obs4, e);
            end
            if (t == 4) begin
                tests_run++;
                if (h4 !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL first_advance hcount=%0d exp=1", h4);
                end
            end
            exp_q.push_back(model(t + 1, 4));
            @(negedge clk_sys);
            t++;
        end
    endtask

    task automatic test_line();
        obs_t e;
        int   hb_cnt = 0;
        int   hs_cnt = 0;
        do_reset();
        exp_q.push_back(model(0, 4));
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs4 !== e) begin
                tests_failed++;
                $display("FAIL line t=%0d got=%h exp=%h", t, obs4, e);
            end
            hb_cnt += int'(hb4);
            hs_cnt += int'(hs4);
            exp_q.push_back(model(t + 1, 4));
            @(negedge clk_sys);
            t++;
        end
        tests_run++;
        if (hb_cnt != 32) begin
            tests_failed++;
            $display("FAIL hblank_width got=%0d exp=32", hb_cnt);
        end
        tests_run++;
        if (hs_cnt != 12) begin
            tests_failed++;
            $display("FAIL hsync_width got=%0d exp=12", hs_cnt);
        end
        tests_run++;
        if (h4 !== 4'd0 || v4 !== 3'd1) begin
            tests_failed++;
            $display("FAIL line_period t=%0d h=%0d v=%0d exp h=0 v=1", t, h4, v4);
        end
    endtask

    task automatic test_frame();
        obs_t e;
        int   vb_cnt  = 0;
        int   vs_cnt  = 0;
        int   rise_t  = -1;
        logic prev_vs = 1'b0;
        do_reset();
        exp_q.push_back(model(0, 4));
        for (int i = 0; i < 520; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs4 !== e) begin
                tests_failed++;
                $display("FAIL frame t=%0d got=%h exp=%h", t, obs4, e);
            end
            if (t < 512) begin
                vb_cnt += int'(vb4);
                vs_cnt += int'(vs4);
                if (vs4 && !prev_vs && rise_t < 0) begin
                    rise_t = t;
                    tests_run++;
                    if (h4 !== 4'd0 || v4 !== 3'd5) begin
                        tests_failed++;
                        $display("FAIL vsync_rise h=%0d v=%0d exp h=0 v=5", h4, v4);
                    end
                end
                prev_vs = vs4;
            end
            if (t == 511) begin
                tests_run++;
                if (h4 !== 4'd15 || v4 !== 3'd7) begin
                    tests_failed++;
                    $display("FAIL pre_wrap h=%0d v=%0d exp h=15 v=7", h4, v4);
                end
            end
            if (t == 512) begin
                tests_run++;
                if ({h4, v4, hs4, vs4, hb4, vb4} !== 11'd0) begin
                    tests_failed++;
                    $display("FAIL frame_wrap h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b exp all 0",
                             h4, v4, hs4, vs4, hb4, vb4);
                end
            end
            exp_q.push_back(model(t + 1, 4));
            @(negedge clk_sys);
            t++;
        end
        tests_run++;
        if (vb_cnt != 256) begin
            tests_failed++;
            $display("FAIL vblank_width got=%0d exp=256", vb_cnt);
        end
        tests_run++;
        if (vs_cnt != 128) begin
            tests_failed++;
            $display("FAIL vsync_width got=%0d exp=128", vs_cnt);
        end
        tests_run++;
        if (rise_t != 320) begin
            tests_failed++;
            $display("FAIL vsync_rise_cycle got=%0d exp=320", rise_t);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e;
        do_reset();
        exp_q.push_back(model(0, 4));
        // Pixel 37 = (5,2); cycle 149 is its second divider phase.
        for (int i = 0; i < 149; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs4 !== e) begin
                tests_failed++;
                $display("FAIL pre_reset t=%0d got=%h exp=%h", t, obs4, e);
            end
            exp_q.push_back(model(t + 1, 4));
            @(negedge clk_sys);
            t++;
        end
        tests_run++;
        if (h4 !== 4'd5 || v4 !== 3'd2) begin
            tests_failed++;
            $display("FAIL reset_point h=%0d v=%0d exp h=5 v=2", h4, v4);
        end
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        t = 0;
        tests_run++;
        if (obs4 !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_state got=%h exp=%h", obs4, obs_t'(0));
        end
        exp_q.push_back(model(0, 4));
        for (int i = 0; i < 24; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs4 !== e) begin
                tests_failed++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t, obs4, e);
            end
            exp_q.push_back(model(t + 1, 4));
            @(negedge clk_sys);
            t++;
        end
    endtask

    task automatic test_ce_div1();
        obs_t e;
        int   wrap0  = -1;
        int   wrap1  = -1;
        logic [3:0] prev_h = 4'd0;
        do_reset();
        exp_q.push_back(model(0, 1));
        for (int i = 0; i < 40; i++) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs1 !== e) begin
                tests_failed++;
                $display("FAIL ce_div1 t=%0d got=%h exp=%h", t, obs1, e);
            end
            if (t > 0 && h1 == 4'd0 && prev_h == 4'd15) begin
                if (wrap0 < 0) wrap0 = t;
                else if (wrap1 < 0) wrap1 = t;
            end
            prev_h = h1;
            exp_q.push_back(model(t + 1, 1));
            @(negedge clk_sys);
            t++;
        end
        tests_run++;
        if (wrap0 != 17 || wrap1 - wrap0 != 16) begin
            tests_failed++;
            $display("FAIL div1_line_period wraps=%0d,%0d exp 17,33", wrap0, wrap1);
        end
    endtask

    initial begin
        test_reset();
        test_ce_schedule();
        test_line();
        test_frame();
        test_mid_reset();
        test_ce_div1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
